// File: rtl/controlador_esteira_if.sv
// controlador_esteira_if: command, sensor and status bundle between fsm_mestre and the conveyor controller
interface controlador_esteira_if;
  logic cmd_mover_esteira, pausa, limpar_falha;
  logic sensor_enchimento, sensor_cq, sensor_final;
  logic motor_ligado, esteira_concluida, falha_timeout;
  logic [1:0] destino;
  modport master(
    output cmd_mover_esteira, pausa, limpar_falha, sensor_enchimento, sensor_cq, sensor_final,
    input motor_ligado, esteira_concluida, falha_timeout, destino
  );
  modport slave(
    input cmd_mover_esteira, pausa, limpar_falha, sensor_enchimento, sensor_cq, sensor_final,
    output motor_ligado, esteira_concluida, falha_timeout, destino
  );
endinterface

// File: rtl/controlador_esteira.sv
// controlador_esteira: belt motor control with debounced station sensors, movement timeout and pause
module controlador_esteira #(
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int TIMEOUT_CICLOS = 250000000
) (
  input logic clk,
  input logic reset,
  controlador_esteira_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CICLOS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CICLOS - 1);
  typedef enum logic [2:0] {PARADO, MOVENDO, PAUSADO, CONCLUIDO, FALHA} state_t;
  state_t state_q, state_d;
  logic [1:0] destino_q, destino_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0] raw, deb_q, deb_d, prev_q, rise;
  logic [DW-1:0] dcnt_q [3];
  logic [DW-1:0] dcnt_d [3];
  logic hit, cmd, motor_q, concl_q, falha_q;
  assign raw = {bus.sensor_final, bus.sensor_cq, bus.sensor_enchimento};
  assign rise = deb_q & ~prev_q;
  assign hit = destino_q == 2'd0 ? rise[0] : destino_q == 2'd1 ? rise[1] : rise[2];
  assign cmd = bus.cmd_mover_esteira;
  assign bus.motor_ligado = motor_q;
  assign bus.esteira_concluida = concl_q;
  assign bus.falha_timeout = falha_q;
  assign bus.destino = destino_q;
  always_comb begin
    deb_d = deb_q;
    for (int k = 0; k < 3; k++) begin
      dcnt_d[k] = raw[k] == deb_q[k] ? '0 : dcnt_q[k] + DW'(1);
      if (raw[k] != deb_q[k] && dcnt_q[k] == D_LAST) begin
        deb_d[k] = ~deb_q[k];
        dcnt_d[k] = '0;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    destino_d = destino_q;
    tcnt_d = tcnt_q;
    case (state_q)
      PARADO: begin
        state_d = cmd ? MOVENDO : PARADO;
        tcnt_d = cmd ? '0 : tcnt_q;
      end
      MOVENDO: begin
        state_d = hit ? CONCLUIDO : !cmd ? PARADO : tcnt_q == T_LAST ? FALHA : bus.pausa ? PAUSADO : MOVENDO;
        tcnt_d = state_d == MOVENDO ? tcnt_q + TW'(1) : tcnt_q;
      end
      PAUSADO: state_d = hit ? CONCLUIDO : !cmd ? PARADO : bus.pausa ? PAUSADO : MOVENDO;
      CONCLUIDO: begin
        state_d = cmd ? CONCLUIDO : PARADO;
        destino_d = cmd ? destino_q : destino_q == 2'd2 ? 2'd0 : destino_q + 2'd1;
      end
      FALHA: state_d = bus.limpar_falha && !cmd ? PARADO : FALHA;
      default: state_d = PARADO;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PARADO;
      destino_q <= '0;
      tcnt_q <= '0;
      deb_q <= '0;
      prev_q <= '0;
      dcnt_q <= '{default: '0};
      motor_q <= 1'b0;
      concl_q <= 1'b0;
      falha_q <= 1'b0;
    end else begin
      state_q <= state_d;
      destino_q <= destino_d;
      tcnt_q <= tcnt_d;
      deb_q <= deb_d;
      prev_q <= deb_q;
      dcnt_q <= dcnt_d;
      motor_q <= state_d == MOVENDO;
      concl_q <= state_d == CONCLUIDO;
      falha_q <= state_d == FALHA;
    end
  end
endmodule

// File: tb/tb_controlador_esteira.sv
// tb_controlador_esteira: vector table, corner sequences and randomized run against a behavioural model
module tb_controlador_esteira;
  localparam int D = 4, T = 50;
  localparam int IDLE = 0, RUN = 1, HOLD = 2, DONE = 3, FAULT = 4;
  logic clk = 1'b0, reset;
  always #5 clk = ~clk;
  controlador_esteira_if bi();
  controlador_esteira #(.DEBOUNCE_CICLOS(D), .TIMEOUT_CICLOS(T)) dut(.clk(clk), .reset(reset), .bus(bi));
  typedef struct {
    int n;
    logic cmd, pau;
    logic [2:0] sen;
    logic lim, rst;
    logic [4:0] want;
  } vec_t;
  vec_t tbl[$];
  int n_cmp = 0, n_bad = 0;
  int m_st = IDLE, m_dest = 0, m_el = 0;
  int run [3];
  bit deb [3], rose [3];
  function automatic logic [4:0] dut_out();
    return {bi.motor_ligado, bi.esteira_concluida, bi.falha_timeout, bi.destino};
  endfunction
  function automatic logic [4:0] mdl_out();
    return {m_st == RUN, m_st == DONE, m_st == FAULT, 2'(m_dest)};
  endfunction
  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got motor/concl/falha/destino=%b want %b at %0t", nm, act, want, $time);
    end
  endtask
  task automatic model_step();
    logic [2:0] r;
    bit hit;
    r = {bi.sensor_final, bi.sensor_cq, bi.sensor_enchimento};
    if (reset) begin
      m_st = IDLE;
      m_dest = 0;
      m_el = 0;
      for (int k = 0; k < 3; k++) begin
        run[k] = 0;
        deb[k] = 0;
        rose[k] = 0;
      end
      return;
    end
    hit = rose[m_dest];
    case (m_st)
      IDLE: if (bi.cmd_mover_esteira) begin m_st = RUN; m_el = 0; end
      RUN: begin
        if (hit) m_st = DONE;
        else if (!bi.cmd_mover_esteira) m_st = IDLE;
        else if (m_el == T - 1) m_st = FAULT;
        else if (bi.pausa) m_st = HOLD;
        else m_el++;
      end
      HOLD: begin
        if (hit) m_st = DONE;
        else if (!bi.cmd_mover_esteira) m_st = IDLE;
        else if (!bi.pausa) m_st = RUN;
      end
      DONE: if (!bi.cmd_mover_esteira) begin m_st = IDLE; m_dest = (m_dest + 1) % 3; end
      default: if (bi.limpar_falha && !bi.cmd_mover_esteira) m_st = IDLE;
    endcase
    for (int k = 0; k < 3; k++) begin
      rose[k] = 0;
      if (r[k] == deb[k]) run[k] = 0;
      else begin
        run[k]++;
        if (run[k] == D) begin
          deb[k] = !deb[k];
          run[k] = 0;
          rose[k] = deb[k];
        end
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", dut_out(), mdl_out());
  endtask
  task automatic drive(input logic c, input logic p, input logic [2:0] s, input logic l, input logic r);
    bi.cmd_mover_esteira = c;
    bi.pausa = p;
    {bi.sensor_final, bi.sensor_cq, bi.sensor_enchimento} = s;
    bi.limpar_falha = l;
    reset = r;
  endtask
  task automatic add(input int n, input logic c, input logic p, input logic [2:0] s, input logic l,
                     input logic r, input logic [4:0] w);
    vec_t v;
    v.n = n; v.cmd = c; v.pau = p; v.sen = s; v.lim = l; v.rst = r; v.want = w;
    tbl.push_back(v);
  endtask
  initial begin
    logic [2:0] s;
    int rate;
    drive(0, 0, 3'b000, 0, 1);
    add(2, 0, 0, 3'b000, 0, 1, 5'b00000);
    add(1, 1, 0, 3'b000, 0, 0, 5'b10000);
    add(4, 1, 0, 3'b001, 0, 0, 5'b10000);
    add(1, 1, 0, 3'b001, 0, 0, 5'b01000);
    add(3, 1, 0, 3'b001, 0, 0, 5'b01000);
    add(1, 0, 0, 3'b001, 0, 0, 5'b00001);
    add(1, 1, 0, 3'b000, 0, 0, 5'b10001);
    add(4, 1, 0, 3'b010, 0, 0, 5'b10001);
    add(1, 1, 0, 3'b010, 0, 0, 5'b01001);
    add(1, 0, 0, 3'b010, 0, 0, 5'b00010);
    add(1, 1, 0, 3'b000, 0, 0, 5'b10010);
    add(4, 1, 0, 3'b100, 0, 0, 5'b10010);
    add(1, 1, 0, 3'b100, 0, 0, 5'b01010);
    add(1, 0, 0, 3'b100, 0, 0, 5'b00000);
    add(5, 0, 0, 3'b000, 0, 0, 5'b00000);
    add(1, 1, 0, 3'b000, 0, 0, 5'b10000);
    add(3, 1, 0, 3'b001, 0, 0, 5'b10000);
    add(10, 1, 0, 3'b000, 0, 0, 5'b10000);
    add(10, 1, 0, 3'b010, 0, 0, 5'b10000);
    add(1, 0, 0, 3'b010, 0, 0, 5'b00000);
    add(5, 0, 0, 3'b000, 0, 0, 5'b00000);
    add(1, 1, 0, 3'b000, 0, 0, 5'b10000);
    add(49, 1, 0, 3'b000, 0, 0, 5'b10000);
    add(1, 1, 0, 3'b000, 0, 0, 5'b00100);
    add(2, 1, 0, 3'b000, 1, 0, 5'b00100);
    add(2, 0, 0, 3'b000, 0, 0, 5'b00100);
    add(1, 0, 0, 3'b000, 1, 0, 5'b00000);
    add(1, 1, 0, 3'b000, 0, 0, 5'b10000);
    add(19, 1, 0, 3'b000, 0, 0, 5'b10000);
    add(100, 1, 1, 3'b000, 0, 0, 5'b00000);
    add(31, 1, 0, 3'b000, 0, 0, 5'b10000);
    add(1, 1, 0, 3'b000, 0, 0, 5'b00100);
    add(1, 0, 0, 3'b000, 1, 0, 5'b00000);
    foreach (tbl[i]) begin
      drive(tbl[i].cmd, tbl[i].pau, tbl[i].sen, tbl[i].lim, tbl[i].rst);
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d", i), dut_out(), tbl[i].want);
    end
    drive(1, 0, 3'b000, 0, 0);
    tick();
    drive(1, 0, 3'b001, 0, 0);
    repeat (5) tick();
    check("concl_enchimento", dut_out(), 5'b01000);
    drive(0, 0, 3'b000, 0, 0);
    tick();
    check("advance_to_cq", dut_out(), 5'b00001);
    drive(1, 0, 3'b000, 0, 0);
    tick();
    check("moving_to_cq", dut_out(), 5'b10001);
    drive(1, 0, 3'b000, 0, 1);
    tick();
    check("reset_mid_move", dut_out(), 5'b00000);
    drive(0, 0, 3'b000, 0, 0);
    repeat (6) tick();
    drive(1, 0, 3'b000, 0, 0);
    repeat (46) tick();
    check("sim_before_sensor", dut_out(), 5'b10000);
    drive(1, 0, 3'b001, 0, 0);
    repeat (4) tick();
    check("sim_last_move_cycle", dut_out(), 5'b10000);
    tick();
    check("sim_edge_beats_timeout", dut_out(), 5'b01000);
    drive(0, 0, 3'b010, 0, 0);
    repeat (6) tick();
    check("cq_high_idle", dut_out(), 5'b00001);
    drive(1, 0, 3'b010, 0, 0);
    repeat (10) tick();
    check("already_high_no_concl", dut_out(), 5'b10001);
    drive(0, 0, 3'b000, 0, 1);
    tick();
    reset = 0;
    s = 3'b000;
    for (int i = 0; i < 4000; i++) begin
      rate = i < 2000 ? 6 : 40;
      reset = $urandom_range(599) == 0;
      if (m_st == DONE ? $urandom_range(2) == 0 : $urandom_range(24) == 0)
        bi.cmd_mover_esteira = ~bi.cmd_mover_esteira;
      if ($urandom_range(39) == 0) bi.pausa = ~bi.pausa;
      bi.limpar_falha = $urandom_range(5) == 0;
      for (int k = 0; k < 3; k++) if ($urandom_range(rate - 1) == 0) s[k] = ~s[k];
      {bi.sensor_final, bi.sensor_cq, bi.sensor_enchimento} = s;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
